// File: rtl/hist_curve_calc.sv
// Histogram read-back and tone-curve generator: reads one block of 128 bins from
// the idle ping-pong bank, streams a saturated CDF curve and optionally clears each bin.
module hist_curve_calc #(
    parameter int LEVELS = 128,
    parameter int BLK_W  = 4,
    parameter int CDF_W  = 23
) (
    input  logic                          pclk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [BLK_W-1:0]              block_idx_i,
    input  logic                          bank_i,
    input  logic [4:0]                    shift_i,
    input  logic                          clear_en_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          bank_o,
    output logic                          rd_cen_o,
    output logic [BLK_W+$clog2(LEVELS)-1:0] addr_rd_o,
    input  logic [7:0]                    data_rd_i,
    output logic                          wr_cen_o,
    output logic                          wr_wen_o,
    output logic [BLK_W+$clog2(LEVELS)-1:0] addr_wr_o,
    output logic [7:0]                    data_wr_o,
    output logic [BLK_W+$clog2(LEVELS)-1:0] reg_addr_rd_o,
    input  logic [7:0]                    reg_data_rd_i,
    output logic [BLK_W+$clog2(LEVELS)-1:0] reg_addr_wr_o,
    output logic [7:0]                    reg_data_wr_o,
    output logic                          reg_enable_o,
    output logic                          curve_valid_o,
    input  logic                          curve_ready_i,
    output logic [7:0]                    curve_data_o,
    output logic [$clog2(LEVELS)-1:0]     curve_idx_o,
    output logic                          curve_last_o,
    output logic [1:0]                    dbg_state_o
);

    // Handshake: an entry transfers on a rising pclk edge where curve_valid_o and
    // curve_ready_i are both high; while valid is high and ready low the entry
    // (data, idx, last) is held unchanged and valid stays high.

    localparam int IDX_W = $clog2(LEVELS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             bank_q, bank_d;
    logic [4:0]       shift_q, shift_d;
    logic             clr_q, clr_d;
    logic [IDX_W-1:0] issue_idx_q, issue_idx_d;
    logic             in_flight_q, in_flight_d;
    logic [IDX_W-1:0] ret_idx_q, ret_idx_d;
    logic [7:0]       lo_q, lo_d;
    logic [CDF_W-1:0] cdf_q, cdf_d;

    logic [7:0]       fifo_data_q [2];
    logic [7:0]       fifo_data_d [2];
    logic [IDX_W-1:0] fifo_idx_q [2];
    logic [IDX_W-1:0] fifo_idx_d [2];
    logic             fifo_last_q [2];
    logic             fifo_last_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       fifo_cnt_q, fifo_cnt_d;

    logic             pop;
    logic             push;
    logic [2:0]       occupancy;
    logic             issue;
    logic [15:0]      bin_count;
    logic [CDF_W-1:0] cdf_next;
    logic [CDF_W-1:0] cdf_shifted;
    logic [7:0]       curve_val;
    logic             ret_last;

    assign pop  = (fifo_cnt_q != 2'd0) && curve_ready_i;
    assign push = in_flight_q;

    // Counting the in-flight read guarantees its return always finds a free FIFO slot.
    assign occupancy = 3'(fifo_cnt_q) + 3'(in_flight_q) - 3'(pop);
    assign issue     = (state_q == S_ISSUE) && (occupancy < 3'd2);

    assign bin_count   = {data_rd_i, lo_q};
    assign cdf_next    = cdf_q + CDF_W'(bin_count);
    assign cdf_shifted = cdf_next >> shift_q;
    assign curve_val   = (|cdf_shifted[CDF_W-1:8]) ? 8'hFF : cdf_shifted[7:0];
    assign ret_last    = (ret_idx_q == IDX_W'(LEVELS - 1));

    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        bank_d      = bank_q;
        shift_d     = shift_q;
        clr_d       = clr_q;
        issue_idx_d = issue_idx_q;
        cdf_d       = cdf_q;
        in_flight_d = issue;
        ret_idx_d   = ret_idx_q;
        lo_d        = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_ISSUE;
                    blk_d       = block_idx_i;
                    bank_d      = bank_i;
                    shift_d     = shift_i;
                    clr_d       = clear_en_i;
                    issue_idx_d = '0;
                    cdf_d       = '0;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    issue_idx_d = issue_idx_q + 1'b1;
                    if (issue_idx_q == IDX_W'(LEVELS - 1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!in_flight_q && ((fifo_cnt_q == 2'd0) || ((fifo_cnt_q == 2'd1) && pop))) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            lo_d      = reg_data_rd_i;
            ret_idx_d = issue_idx_q;
        end
        if (in_flight_q) begin
            cdf_d = cdf_next;
        end
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_idx_d  = fifo_idx_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q + 2'(push) - 2'(pop);
        if (push) begin
            fifo_data_d[wr_ptr_q] = curve_val;
            fifo_idx_d[wr_ptr_q]  = ret_idx_q;
            fifo_last_d[wr_ptr_q] = ret_last;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            blk_q       <= '0;
            bank_q      <= 1'b0;
            shift_q     <= '0;
            clr_q       <= 1'b0;
            issue_idx_q <= '0;
            in_flight_q <= 1'b0;
            ret_idx_q   <= '0;
            lo_q        <= '0;
            cdf_q       <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_idx_q[i]  <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            bank_q      <= bank_d;
            shift_q     <= shift_d;
            clr_q       <= clr_d;
            issue_idx_q <= issue_idx_d;
            in_flight_q <= in_flight_d;
            ret_idx_q   <= ret_idx_d;
            lo_q        <= lo_d;
            cdf_q       <= cdf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= fifo_data_d[i];
                fifo_idx_q[i]  <= fifo_idx_d[i];
                fifo_last_q[i] <= fifo_last_d[i];
            end
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign bank_o      = bank_q;
    assign dbg_state_o = state_q;

    assign rd_cen_o      = ~issue;
    assign addr_rd_o     = {blk_q, issue_idx_q};
    assign reg_addr_rd_o = {blk_q, issue_idx_q};

    // The clear trails the read by one cycle, so each bin is zeroed as its count returns.
    assign wr_cen_o      = ~(in_flight_q & clr_q);
    assign wr_wen_o      = ~(in_flight_q & clr_q);
    assign addr_wr_o     = {blk_q, ret_idx_q};
    assign data_wr_o     = 8'h00;
    assign reg_enable_o  = in_flight_q & clr_q;
    assign reg_addr_wr_o = {blk_q, ret_idx_q};
    assign reg_data_wr_o = 8'h00;

    assign curve_valid_o = (fifo_cnt_q != 2'd0);
    assign curve_data_o  = curve_valid_o ? fifo_data_q[rd_ptr_q] : 8'h00;
    assign curve_idx_o   = curve_valid_o ? fifo_idx_q[rd_ptr_q] : '0;
    assign curve_last_o  = curve_valid_o & fifo_last_q[rd_ptr_q];

endmodule

// File: doc/hist_curve_calc.md
# hist_curve_calc

Histogram read-back and tone-curve generator on the idle side of the ping-pong histogram memory. For one block, it reads all 128 bins, combining the 8-bit SRAM high count with the 8-bit register-file low count. It accumulates an inclusive CDF and streams a saturated 8-bit curve value per bin over valid/ready. It can also clear each bin to zero behind the read, so the bank is empty before the statistics writer toggles back to it.

## Interface
Parameters:
- LEVELS, 128, histogram bins per block (index width 7)
- BLK_W, 4, block index width; memory address = {block, bin} = 11 bits
- CDF_W, 23, accumulator width (128 × 65535 fits)

Ports:
- pclk  in  1  clock
- rst  in  1  reset (one clock; reset is synchronous and active-high)
- start_i  in  1  start pulse; sampled only in IDLE
- block_idx_i  in  4  block to process; latched on start
- bank_i  in  1  bank to read/clear; latched on start, driven on bank_o
- shift_i  in  5  CDF normalisation right-shift; latched on start
- clear_en_i  in  1  zero each bin after reading it; latched on start
- busy_o  out  1  high from the cycle after start until done_o
- done_o  out  1  one-cycle pulse after the last curve handshake
- bank_o  out  1  latched bank_i
- rd_cen_o  out  1  SRAM read chip enable, active low
- addr_rd_o  out  11  SRAM read address; data_rd_i valid the next cycle
- data_rd_i  in  8  SRAM high count
- wr_cen_o, wr_wen_o  out  1 each  SRAM write enables, active low
- addr_wr_o  out  11  SRAM clear address
- data_wr_o  out  8  always 0
- reg_addr_rd_o  out  11  regfile read address; reg_data_rd_i is combinational (same cycle)
- reg_data_rd_i  in  8  regfile low count
- reg_addr_wr_o  out  11  regfile clear address
- reg_data_wr_o  out  8  always 0
- reg_enable_o  out  1  regfile write strobe
- curve_valid_o  out  1  curve entry available
- curve_ready_i  in  1  downstream accept
- curve_data_o  out  8  curve value
- curve_idx_o  out  7  bin index of the entry
- curve_last_o  out  1  high with idx 127

## Operation
- FSM states:
  - IDLE, start_i → ISSUE. Clear CDF, issue index and in-flight flag; latch the configuration.
  - ISSUE: issue one bin per cycle when permitted; after index 127 is issued → DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight → DONE.
  - DONE: done_o = 1 for one cycle → IDLE.
- Issue of bin i (cycle I):
  - rd_cen_o = 0, addr_rd_o = {blk, i}.
  - reg_addr_rd_o = {blk, i}; the block registers reg_data_rd_i at the end of cycle I.
- Return (cycle I+1):
  - count = {data_rd_i, lo_q} (16 bits); cdf_next = cdf + count.
  - Entry pushed into a 2-deep output FIFO: data = (cdf_next >> shift) > 255 ? 255 : (cdf_next >> shift)[7:0], idx = i, last = (i == 127).
  - If clear is enabled, in the same cycle: wr_cen_o = wr_wen_o = 0, addr_wr_o = {blk, i}; reg_enable_o = 1, reg_addr_wr_o = {blk, i}; zero data on both.
- Issue permitted when (fifo_count + in_flight − pop_this_cycle) < 2, so a returning read never overflows the FIFO.
- Handshake: the entry pops when curve_valid_o & curve_ready_i. Data, idx and last are held stable while valid is high and ready is low. Valid never drops without a pop.
- Entries are emitted in strictly increasing idx, 0..127, exactly once per run.

## Timing
- Reset values:
  - busy_o, done_o, curve_valid_o, curve_last_o, reg_enable_o = 0.
  - rd_cen_o, wr_cen_o, wr_wen_o = 1.
  - All addresses, curve_data_o, curve_idx_o, bank_o = 0.
- Start sampled at cycle T → busy_o at T+1, first issue at T+1, first return/clear at T+2, first curve_valid_o at T+3.
- With curve_ready_i held high: one entry per cycle, idx 127 valid at T+130, done_o at T+131, busy_o low at T+132.
- Backpressure: issue stalls at most 2 entries ahead. Resuming ready resumes issue in the same cycle a pop occurs.
- start_i while busy: ignored. The latched configuration does not change mid-run.
- Reset mid-run: next cycle is IDLE with all outputs at reset values. No further reads or clears; bins already cleared stay cleared.
- CDF arithmetic is unsigned, CDF_W bits, no wrap for legal inputs. A shift_i ≥ 23 gives 0.

## Test plan
- All bins zero, shift 7, ready high: 128 entries of 0, idx 0..127, last only on 127, done_o at T+131.
- Bin 5 = {hi 0x80, lo 0x00} (32768), others zero, shift 7: idx 0–4 → 0, idx 5–127 → 255 (saturated).
- Every bin = {0x01, 0x00} (256), shift 8: curve_data at idx i = i+1 for i ≤ 254; idx 127 → 128.
- Random curve_ready_i (≈50%): same data sequence as with ready high. No stable-hold violation. FIFO never exceeds 2 entries.
- clear_en_i = 1, block 3, bank 1: after done, every {3, i} address reads 0 in both memories. Block 2 is untouched. With clear_en_i = 0, no write strobes occur.
- Assert rst at bin 40, then start a new run: no writes after the reset cycle, busy_o low, and the new run starts cleanly at idx 0 with the CDF from zero.
